// File: rtl/sd_drive_arbiter_if.sv
// Bundle between the FDC drive units and the hps_io SD sector channel.
// The arbiter takes the master modport; requesters and hps_io take slave.
interface sd_drive_arbiter_if #(
  parameter int NUM_DRIVES = 2
);
  logic [NUM_DRIVES-1:0]    drv_rd;
  logic [NUM_DRIVES-1:0]    drv_wr;
  logic [32*NUM_DRIVES-1:0] drv_lba;
  logic [8*NUM_DRIVES-1:0]  drv_buff_din;
  logic [NUM_DRIVES-1:0]    drv_buff_wr;
  logic [NUM_DRIVES-1:0]    drv_done;
  logic [NUM_DRIVES-1:0]    drv_err;
  logic [31:0]              sd_lba;
  logic [NUM_DRIVES-1:0]    sd_rd;
  logic [NUM_DRIVES-1:0]    sd_wr;
  logic                     sd_ack;
  logic                     sd_buff_wr;
  logic [7:0]               sd_buff_din;
  logic                     busy;

  modport master (
    input  drv_rd, drv_wr, drv_lba, drv_buff_din, sd_ack, sd_buff_wr,
    output drv_buff_wr, drv_done, drv_err, sd_lba, sd_rd, sd_wr, sd_buff_din, busy
  );

  modport slave (
    output drv_rd, drv_wr, drv_lba, drv_buff_din, sd_ack, sd_buff_wr,
    input  drv_buff_wr, drv_done, drv_err, sd_lba, sd_rd, sd_wr, sd_buff_din, busy
  );
endinterface

// File: rtl/sd_drive_arbiter.sv
// Round-robin sharing of the single hps_io SD sector channel among the FDC drive units.
// One transfer at a time: IDLE -> REQ -> XFER -> DONE, with a timeout abort out of REQ.
module sd_drive_arbiter #(
  parameter int NUM_DRIVES     = 2,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic               clk_sys,
  input  logic               reset,
  sd_drive_arbiter_if.master bus
);
  localparam int GW = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         r_last;
  logic [31:0]           r_lba;
  logic                  r_abort;
  logic                  r_holdoff;
  logic [TW-1:0]         r_tmo;
  logic [NUM_DRIVES-1:0] r_sd_rd;
  logic [NUM_DRIVES-1:0] r_sd_wr;

  logic [NUM_DRIVES-1:0] w_elig;
  logic [NUM_DRIVES-1:0] w_pick_oh;
  logic [GW-1:0]         w_pick;
  logic                  w_found;

  // Round-robin pick starting just after the previous grant; the drive just
  // served sits out the first IDLE cycle so it can drop its request.
  always_comb begin
    int idx;
    idx     = 0;
    w_elig  = (bus.drv_rd | bus.drv_wr) &
              ~(r_holdoff ? (NUM_DRIVES'(1) << r_grant) : '0);
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = 1; k <= NUM_DRIVES; k++) begin
      idx = (int'(r_last) + k) % NUM_DRIVES;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_pick  = GW'(idx);
      end
    end
    w_pick_oh = NUM_DRIVES'(1) << w_pick;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // A stale sd_ack left high from a previous transfer blocks new requests.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!bus.sd_ack && w_found) w_next = S_REQ;
      S_REQ:   if (bus.sd_ack) w_next = S_XFER;
               else if (r_tmo == TLAST) w_next = S_DONE;
      S_XFER:  if (!bus.sd_ack) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_grant   <= '0;
      r_last    <= GW'(NUM_DRIVES - 1);
      r_lba     <= '0;
      r_abort   <= 1'b0;
      r_holdoff <= 1'b0;
      r_tmo     <= '0;
      r_sd_rd   <= '0;
      r_sd_wr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_holdoff <= 1'b0;
          r_abort   <= 1'b0;
          r_tmo     <= '0;
          if (w_next == S_REQ) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_lba   <= bus.drv_lba[32*int'(w_pick) +: 32];
            r_sd_rd <= bus.drv_rd[w_pick] ? w_pick_oh : '0;
            r_sd_wr <= bus.drv_rd[w_pick] ? '0 : w_pick_oh;
          end
        end
        S_REQ: begin
          if (bus.sd_ack) begin
            r_sd_rd <= '0;
            r_sd_wr <= '0;
          end else if (r_tmo == TLAST) begin
            r_sd_rd <= '0;
            r_sd_wr <= '0;
            r_abort <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DONE:  r_holdoff <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy        = (r_state != S_IDLE);
    bus.drv_done    = '0;
    bus.drv_err     = '0;
    bus.drv_buff_wr = '0;
    bus.sd_buff_din = '0;
    if (r_state == S_DONE) begin
      bus.drv_done[r_grant] = 1'b1;
      bus.drv_err[r_grant]  = r_abort;
    end
    if (r_state == S_REQ || r_state == S_XFER)
      bus.drv_buff_wr[r_grant] = bus.sd_buff_wr;
    if (r_state != S_IDLE)
      bus.sd_buff_din = bus.drv_buff_din[8*int'(r_grant) +: 8];
  end

  assign bus.sd_lba = r_lba;
  assign bus.sd_rd  = r_sd_rd;
  assign bus.sd_wr  = r_sd_wr;

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// Bench for sd_drive_arbiter: directed corner cases, then randomized traffic
// scored against a round-robin service model and a behavioural hps_io responder.
module tb_sd_drive_arbiter;
  localparam int N   = 2;
  localparam int TMO = 16;

  typedef struct { int drv; bit rd; logic [31:0] lba; } req_t;
  typedef struct { int drv; bit err; int cyc; } dn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_drive_arbiter_if #(.NUM_DRIVES(N)) bus ();
  sd_drive_arbiter #(.NUM_DRIVES(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys(clk), .reset(rst), .bus(bus)
  );

  logic         hps_en, sb_en;
  logic         m_ack, m_bwr, h_ack, h_bwr;
  logic [15:0]  m_din, h_din;
  assign bus.sd_ack       = hps_en ? h_ack : m_ack;
  assign bus.sd_buff_wr   = hps_en ? h_bwr : m_bwr;
  assign bus.drv_buff_din = hps_en ? h_din : m_din;

  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   m_last, cur_drv;
  req_t pq[N][$];
  dn_t  dq[$];
  int   reps[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 read only, 1 write only, 2 both (read must win)
  task automatic issue(input int d, input int kind);
    req_t e;
    e.drv = d;
    e.rd  = (kind != 1);
    e.lba = $urandom;
    bus.drv_rd[d] = (kind != 1);
    bus.drv_wr[d] = (kind != 0);
    bus.drv_lba[32*d +: 32] = e.lba;
    pq[d].push_back(e);
  endtask

  // Monitor: grants and completions against the model.
  initial begin
    logic [N-1:0] prev_req, cur_req;
    int   d, i;
    req_t e;
    dn_t  x;
    prev_req = '0;
    forever begin
      @(negedge clk);
      cur_req = bus.sd_rd | bus.sd_wr;
      if (sb_en) begin
        if (cur_req != 0 && prev_req == 0) begin
          d = -1;
          for (int k = 1; k <= N; k++) begin
            i = (m_last + k) % N;
            if (d < 0 && pq[i].size() > 0) d = i;
          end
          if (d < 0) chk("unexpected_grant", 32'(cur_req), 0);
          else begin
            e = pq[d].pop_front();
            chk("grant_sd_rd", 32'(bus.sd_rd), e.rd ? (1 << d) : 0);
            chk("grant_sd_wr", 32'(bus.sd_wr), e.rd ? 0 : (1 << d));
            chk("grant_lba", bus.sd_lba, e.lba);
            m_last  = d;
            cur_drv = d;
          end
        end
        if (bus.drv_done != 0) begin
          if (dq.size() == 0) chk("unexpected_done", 32'(bus.drv_done), 0);
          else begin
            x = dq.pop_front();
            chk("done_drive", 32'(bus.drv_done), 1 << x.drv);
            chk("done_err", 32'(bus.drv_err), x.err ? (1 << x.drv) : 0);
            chk("done_cycle", cyc, x.cyc);
          end
        end else if (bus.drv_err != 0) begin
          chk("err_without_done", 32'(bus.drv_err), 0);
        end
      end
      prev_req = sb_en ? cur_req : '0;
    end
  end

  // hps_io responder: random ack latency, occasional no-ack, random strobes.
  initial begin
    int r0, d, n;
    h_ack = 1'b0; h_bwr = 1'b0; h_din = '0;
    forever begin
      @(negedge clk);
      if (hps_en && (bus.sd_rd | bus.sd_wr) != 0) begin
        r0 = cyc;
        if ($urandom_range(0, 5) == 0) begin
          tick();
          dq.push_back('{drv: cur_drv, err: 1'b1, cyc: r0 + TMO});
          repeat (TMO) @(negedge clk);
          chk("timeout_clears_req", 32'(bus.sd_rd | bus.sd_wr), 0);
        end else begin
          d = $urandom_range(1, 8);
          repeat (d) tick();
          h_ack = 1'b1;
          tick();
          n = $urandom_range(1, 12);
          for (int s = 0; s < n; s++) begin
            h_bwr = 1'($urandom_range(0, 1));
            h_din = 16'($urandom);
            @(negedge clk);
            if (s == 0) chk("req_drops_on_ack", 32'(bus.sd_rd | bus.sd_wr), 0);
            chk("buff_wr_route", 32'(bus.drv_buff_wr), h_bwr ? (1 << cur_drv) : 0);
            chk("buff_din_mux", 32'(bus.sd_buff_din), 32'(h_din[8*cur_drv +: 8]));
            tick();
          end
          h_bwr = 1'b0;
          h_ack = 1'b0;
          dq.push_back('{drv: cur_drv, err: 1'b0, cyc: cyc + 1});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int good, cnt, done_flag;
    logic stale;
    logic [N-1:0] dn, de;

    rst = 1'b1; sb_en = 1'b0; hps_en = 1'b0;
    bus.drv_rd = '0; bus.drv_wr = '0; bus.drv_lba = '0;
    m_ack = 1'b1; m_bwr = 1'b0; m_din = '0;
    bus.drv_rd = 2'b01; bus.drv_lba[31:0] = 32'h12;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_sd_rd", 32'(bus.sd_rd), 0);
    chk("rst_sd_wr", 32'(bus.sd_wr), 0);
    chk("rst_sd_lba", bus.sd_lba, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done_err", 32'({bus.drv_done, bus.drv_err}), 0);
    chk("rst_buff", 32'({bus.drv_buff_wr, bus.sd_buff_din}), 0);

    // Stale ack held across reset release.
    tick(); rst = 1'b0;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if ((bus.sd_rd | bus.sd_wr) != 0 || bus.busy) stale = 1'b1;
      tick();
    end
    chk("stale_ack_blocks_req", 32'(stale), 0);
    m_ack = 1'b0;
    @(negedge clk);
    chk("req_waits_one_cycle", 32'(bus.sd_rd), 0);
    tick(); @(negedge clk);
    chk("single_sd_rd", 32'(bus.sd_rd), 1);
    chk("single_sd_lba", bus.sd_lba, 32'h12);
    tick(); m_ack = 1'b1;
    tick(); @(negedge clk);
    chk("single_rd_drop", 32'(bus.sd_rd), 0);
    tick();
    good = 0;
    for (int s = 0; s < 512; s++) begin
      m_bwr = 1'b1;
      @(negedge clk);
      if (bus.drv_buff_wr == 2'b01 && bus.drv_done == 0) good++;
      tick();
    end
    chk("single_strobes_drv0", good, 512);
    m_bwr = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    chk("single_no_early_done", 32'(bus.drv_done), 0);
    tick(); @(negedge clk);
    chk("single_done", 32'(bus.drv_done), 1);
    chk("single_err", 32'(bus.drv_err), 0);
    tick(); bus.drv_rd = '0;
    @(negedge clk);
    chk("single_done_one_cycle", 32'(bus.drv_done), 0);
    chk("single_idle", 32'(bus.busy), 0);

    // Write data path from drive 1, then reset mid-transfer.
    tick();
    m_din = 16'hA53C; bus.drv_lba[63:32] = 32'h55; bus.drv_wr = 2'b10;
    tick(); @(negedge clk);
    chk("wr_sd_wr", 32'(bus.sd_wr), 2);
    chk("wr_sd_rd", 32'(bus.sd_rd), 0);
    chk("wr_lba", bus.sd_lba, 32'h55);
    tick(); m_ack = 1'b1;
    good = 0;
    for (int s = 0; s < 100; s++) begin
      tick(); @(negedge clk);
      if (bus.sd_buff_din == 8'hA5 && bus.busy && bus.sd_wr == 0) good++;
    end
    chk("wr_din_a5_xfer", good, 100);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_req", 32'(bus.sd_rd | bus.sd_wr), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    stale = 1'b0;
    repeat (5) begin
      if (bus.drv_done != 0 || (bus.sd_rd | bus.sd_wr) != 0) stale = 1'b1;
      tick(); @(negedge clk);
    end
    chk("rst_mid_no_done", 32'(stale), 0);
    tick(); bus.drv_wr = '0; m_ack = 1'b0; m_din = '0;
    tick();

    // Timeout on drive 0.
    bus.drv_rd = 2'b01;
    cnt = 0; dn = '0; de = '0;
    for (int t = 0; t < 40; t++) begin
      tick(); @(negedge clk);
      if (bus.sd_rd == 2'b01) cnt++;
      if (bus.drv_done != 0) begin
        dn = bus.drv_done; de = bus.drv_err;
        break;
      end
    end
    chk("tmo_req_cycles", cnt, TMO);
    chk("tmo_done", 32'(dn), 1);
    chk("tmo_err", 32'(de), 1);
    tick(); bus.drv_rd = '0;
    @(negedge clk);
    chk("tmo_idle", 32'(bus.busy), 0);

    // Randomized traffic; the first batch is the two-drive contention case.
    tick(); rst = 1'b1; m_last = N - 1;
    tick(); tick(); rst = 1'b0;
    sb_en = 1'b1; hps_en = 1'b1;
    for (int b = 0; b < 26; b++) begin
      tick();
      if (b == 0) begin
        reps[0] = 1; reps[1] = 0;
        issue(0, 0); issue(1, 1);
      end else begin
        for (int d = 0; d < N; d++) begin
          reps[d] = $urandom_range(0, 2);
          if ($urandom_range(0, 2) != 0 || d == b % N) issue(d, $urandom_range(0, 2));
          else reps[d] = 0;
        end
      end
      done_flag = 0;
      for (int t = 0; t < 3000; t++) begin
        @(negedge clk);
        dn = bus.drv_done;
        if ((bus.drv_rd | bus.drv_wr) == 0 && dq.size() == 0 && !bus.busy && dn == 0) begin
          done_flag = 1;
          break;
        end
        tick();
        for (int d = 0; d < N; d++) begin
          if (dn[d]) begin
            if (reps[d] > 0) begin
              reps[d]--;
              issue(d, $urandom_range(0, 2));
            end else begin
              bus.drv_rd[d] = 1'b0;
              bus.drv_wr[d] = 1'b0;
            end
          end
        end
      end
      chk("batch_finished", done_flag, 1);
      chk("batch_nothing_pending", pq[0].size() + pq[1].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
